// File: rtl/irq_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : irq_arbiter
//  Purpose  : Masked level/edge interrupt collector with fixed-priority winner
//             selection and a request/acknowledge/complete handler handshake.
//  Revision : 1.0
// ============================================================================
module irq_arbiter #(
    parameter int NSRC = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:2]       Addr,
    input  logic [31:0]      WD,
    input  logic             We,
    output logic [31:0]      RD,
    input  logic [NSRC-1:0]  IrqIn,
    output logic             IntReq
);

    localparam int c_IDW = (NSRC > 1) ? $clog2(NSRC) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_SVC  = 2'd2
    } state_t;

    state_t            r_state;
    logic [c_IDW-1:0]  r_cur;
    logic              r_cool;
    logic [NSRC-1:0]   r_mask;
    logic [NSRC-1:0]   r_mode;
    logic [NSRC-1:0]   r_edge;
    logic [NSRC-1:0]   r_sync;

    logic              w_wrMask;
    logic              w_wrMode;
    logic              w_wrPend;
    logic              w_wrClaim;
    logic              w_ack;
    logic              w_complete;
    logic [NSRC-1:0]   w_curOneHot;
    logic [NSRC-1:0]   w_edgeSet;
    logic [NSRC-1:0]   w_edgeClr;
    logic [NSRC-1:0]   w_pend;
    logic [NSRC-1:0]   w_reqVec;
    logic              w_anyReq;
    logic              w_curReq;
    logic [c_IDW-1:0]  w_win;
    logic              w_unusedWd;

    assign w_wrMask   = We && (Addr == 2'd0);
    assign w_wrMode   = We && (Addr == 2'd1);
    assign w_wrPend   = We && (Addr == 2'd2);
    assign w_wrClaim  = We && (Addr == 2'd3);
    assign w_ack      = w_wrClaim && WD[31];
    assign w_complete = w_wrClaim && !WD[31] && (WD[c_IDW-1:0] == r_cur)
                        && (r_state == S_SVC);

    assign w_curOneHot = NSRC'(1) << r_cur;

    // A new rising edge outranks any clear landing on the same bit.
    assign w_edgeSet = r_mode & IrqIn & ~r_sync;
    assign w_edgeClr = (w_wrPend ? WD[NSRC-1:0] : '0)
                     | (w_complete ? w_curOneHot : '0);

    assign w_pend   = (r_mode & r_edge) | (~r_mode & r_sync);
    assign w_reqVec = w_pend & r_mask;
    assign w_anyReq = |w_reqVec;
    assign w_curReq = w_reqVec[r_cur];

    assign w_unusedWd = ^WD[30:NSRC];

    always_comb begin
        w_win = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_reqVec[i]) begin
                w_win = c_IDW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask <= '0;
            r_mode <= '0;
            r_edge <= '0;
            r_sync <= '0;
        end else begin
            r_sync <= IrqIn;
            r_edge <= (r_edge & ~w_edgeClr) | w_edgeSet;
            if (w_wrMask) begin
                r_mask <= WD[NSRC-1:0];
            end
            if (w_wrMode) begin
                r_mode <= WD[NSRC-1:0];
            end
        end
    end

    // r_cool forces one idle cycle after a completion before re-arbitrating.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cur   <= '0;
            r_cool  <= 1'b0;
            IntReq  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_cool) begin
                        r_cool <= 1'b0;
                    end else if (w_anyReq) begin
                        r_cur   <= w_win;
                        r_state <= S_REQ;
                        IntReq  <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (w_ack) begin
                        r_state <= S_SVC;
                        IntReq  <= 1'b0;
                    end else if (!w_curReq) begin
                        r_state <= S_IDLE;
                        IntReq  <= 1'b0;
                    end
                end
                S_SVC: begin
                    if (w_complete) begin
                        r_state <= S_IDLE;
                        r_cool  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    IntReq  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        RD = '0;
        case (Addr)
            2'd0: RD[NSRC-1:0] = r_mask;
            2'd1: RD[NSRC-1:0] = r_mode;
            2'd2: RD[NSRC-1:0] = w_reqVec;
            2'd3: begin
                RD[31] = (r_state != S_IDLE);
                RD[30] = (r_state == S_SVC);
                RD[c_IDW-1:0] = (r_state != S_IDLE) ? r_cur : '0;
            end
            default: RD = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_irq_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irq_arbiter
//  Purpose  : Directed scenarios plus randomized traffic against a reference model.
//  Revision : 1.0
// ============================================================================
module tb_irq_arbiter;

    logic        clk;
    logic        reset;
    logic [3:2]  Addr;
    logic [31:0] WD;
    logic        We;
    logic [31:0] RD;
    logic [5:0]  IrqIn;
    logic        IntReq;

    int checks;
    int errors;

    // Reference model state: phase 0 = idle, 1 = requesting, 2 = in service.
    bit mMask  [6];
    bit mMode  [6];
    bit mLatch [6];
    bit mSync  [6];
    int mPhase;
    int mCur;
    bit mCool;

    irq_arbiter #(.NSRC(6)) dut (
        .clk    (clk),
        .reset  (reset),
        .Addr   (Addr),
        .WD     (WD),
        .We     (We),
        .RD     (RD),
        .IrqIn  (IrqIn),
        .IntReq (IntReq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_step();
        bit req [6];
        bit nLatch [6];
        int win;
        bit ack;
        bit comp;
        if (reset) begin
            for (int i = 0; i < 6; i++) begin
                mMask[i] = 0; mMode[i] = 0; mLatch[i] = 0; mSync[i] = 0;
            end
            mPhase = 0; mCur = 0; mCool = 0;
            return;
        end
        win = -1;
        for (int i = 0; i < 6; i++) begin
            req[i] = mMask[i] && (mMode[i] ? mLatch[i] : mSync[i]);
            if (req[i] && win < 0) win = i;
        end
        ack  = We && (Addr == 2'd3) && WD[31];
        comp = (mPhase == 2) && We && (Addr == 2'd3) && !WD[31] && (int'(WD[2:0]) == mCur);
        for (int i = 0; i < 6; i++) begin
            if (mMode[i] && IrqIn[i] && !mSync[i])
                nLatch[i] = 1;
            else if ((We && Addr == 2'd2 && WD[i]) || (comp && i == mCur))
                nLatch[i] = 0;
            else
                nLatch[i] = mLatch[i];
        end
        case (mPhase)
            0: begin
                if (mCool) mCool = 0;
                else if (win >= 0) begin mCur = win; mPhase = 1; end
            end
            1: begin
                if (ack) mPhase = 2;
                else if (!req[mCur]) mPhase = 0;
            end
            default: begin
                if (comp) begin mPhase = 0; mCool = 1; end
            end
        endcase
        for (int i = 0; i < 6; i++) begin
            mLatch[i] = nLatch[i];
            mSync[i]  = IrqIn[i];
            if (We && Addr == 2'd0) mMask[i] = WD[i];
            if (We && Addr == 2'd1) mMode[i] = WD[i];
        end
    endtask

    function automatic logic [31:0] mdl_rd(input logic [1:0] a);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 6; i++) begin
            case (a)
                2'd0: v[i] = mMask[i];
                2'd1: v[i] = mMode[i];
                2'd2: v[i] = mMask[i] && (mMode[i] ? mLatch[i] : mSync[i]);
                default: v[i] = 1'b0;
            endcase
        end
        if (a == 2'd3 && mPhase != 0) begin
            v[31]  = 1'b1;
            v[30]  = (mPhase == 2);
            v[2:0] = 3'(mCur);
        end
        return v;
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        We = 1'b1; Addr = a; WD = d;
        cycle();
        We = 1'b0; WD = '0;
    endtask

    task automatic rd_at(input logic [1:0] a);
        Addr = a;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; We = 1'b0; IrqIn = '0;
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; IrqIn = 6'h3F; We = 1'b1; WD = 32'hFFFF_FFFF;
        for (int a = 0; a < 4; a++) begin
            Addr = 2'(a);
            cycle();
        end
        reset = 1'b0; We = 1'b0; IrqIn = '0; WD = '0;
        checks++;
        if (IntReq !== 1'b0) begin errors++; $display("FAIL reset_intreq: got %0b want 0", IntReq); end
        for (int a = 0; a < 4; a++) begin
            rd_at(2'(a));
            checks++;
            if (RD !== 32'h0) begin errors++; $display("FAIL reset_rd%0d: got %h want 0", a, RD); end
        end
    endtask

    task automatic test_level_priority();
        do_reset();
        wr(2'd0, 32'h3F);
        wr(2'd1, 32'h00);
        IrqIn = 6'b001100;
        cycle();
        checks++;
        if (IntReq !== 1'b0) begin errors++; $display("FAIL lvl_early: IntReq=%0b want 0", IntReq); end
        cycle();
        checks++;
        if (IntReq !== 1'b1) begin errors++; $display("FAIL lvl_req: IntReq=%0b want 1", IntReq); end
        rd_at(2'd3);
        checks++;
        if (RD !== 32'h8000_0002) begin errors++; $display("FAIL lvl_claim: got %h want 80000002", RD); end
        wr(2'd3, 32'h8000_0000);
        rd_at(2'd3);
        checks++;
        if (RD !== 32'hC000_0002 || IntReq !== 1'b0) begin
            errors++; $display("FAIL lvl_ack: claim %h intreq %0b want c0000002/0", RD, IntReq);
        end
        IrqIn = 6'b001000;
        wr(2'd3, 32'h0000_0002);
        rd_at(2'd3);
        checks++;
        if (RD !== 32'h0 || IntReq !== 1'b0) begin
            errors++; $display("FAIL lvl_done: claim %h intreq %0b want 0/0", RD, IntReq);
        end
        cycle();
        checks++;
        if (IntReq !== 1'b0) begin errors++; $display("FAIL lvl_cool: IntReq=%0b want 0", IntReq); end
        cycle();
        rd_at(2'd3);
        checks++;
        if (IntReq !== 1'b1 || RD !== 32'h8000_0003) begin
            errors++; $display("FAIL lvl_next: claim %h intreq %0b want 80000003/1", RD, IntReq);
        end
    endtask

    task automatic test_edge_latch();
        do_reset();
        wr(2'd1, 32'h01);
        wr(2'd0, 32'h01);
        IrqIn = 6'b000001;
        cycle();
        IrqIn = '0;
        cycle();
        rd_at(2'd2);
        checks++;
        if (RD !== 32'h1 || IntReq !== 1'b1) begin
            errors++; $display("FAIL edge_pend: pend %h intreq %0b want 1/1", RD, IntReq);
        end
        wr(2'd2, 32'h1);
        cycle();
        rd_at(2'd3);
        checks++;
        if (IntReq !== 1'b0 || RD !== 32'h0) begin
            errors++; $display("FAIL edge_cancel: claim %h intreq %0b want 0/0", RD, IntReq);
        end
        rd_at(2'd2);
        checks++;
        if (RD !== 32'h0) begin errors++; $display("FAIL edge_cleared: pend %h want 0", RD); end
    endtask

    task automatic test_handshake_guard();
        do_reset();
        wr(2'd0, 32'h3F);
        IrqIn = 6'b010000;
        cycle();
        cycle();
        wr(2'd3, 32'h8000_0000);
        wr(2'd3, 32'h0000_0005);
        rd_at(2'd3);
        checks++;
        if (RD !== 32'hC000_0004) begin errors++; $display("FAIL guard_badid: claim %h want c0000004", RD); end
        wr(2'd3, 32'h8000_0004);
        rd_at(2'd3);
        checks++;
        if (RD !== 32'hC000_0004) begin errors++; $display("FAIL guard_reack: claim %h want c0000004", RD); end
        wr(2'd0, 32'h0);
        rd_at(2'd3);
        checks++;
        if (RD !== 32'hC000_0004) begin errors++; $display("FAIL guard_mask: claim %h want c0000004", RD); end
        wr(2'd3, 32'h0000_0004);
        rd_at(2'd3);
        checks++;
        if (RD !== 32'h0 || IntReq !== 1'b0) begin
            errors++; $display("FAIL guard_done: claim %h intreq %0b want 0/0", RD, IntReq);
        end
    endtask

    task automatic test_collision();
        do_reset();
        wr(2'd1, 32'h02);
        wr(2'd0, 32'h02);
        IrqIn = 6'b000010;
        wr(2'd2, 32'h2);
        rd_at(2'd2);
        checks++;
        if (RD !== 32'h2) begin errors++; $display("FAIL collide_latch: pend %h want 2", RD); end
        cycle();
        checks++;
        if (IntReq !== 1'b1) begin errors++; $display("FAIL collide_req: IntReq=%0b want 1", IntReq); end
    endtask

    task automatic test_masking();
        do_reset();
        IrqIn = 6'h3F;
        cycle(); cycle(); cycle();
        checks++;
        if (IntReq !== 1'b0) begin errors++; $display("FAIL mask_off: IntReq=%0b want 0", IntReq); end
        wr(2'd0, 32'h20);
        checks++;
        if (IntReq !== 1'b0) begin errors++; $display("FAIL mask_lat: IntReq=%0b want 0", IntReq); end
        cycle();
        rd_at(2'd3);
        checks++;
        if (IntReq !== 1'b1 || RD !== 32'h8000_0005) begin
            errors++; $display("FAIL mask_src5: claim %h intreq %0b want 80000005/1", RD, IntReq);
        end
    endtask

    task automatic test_random();
        logic [31:0] expRd;
        int prints;
        prints = 0;
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            reset = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 3) == 0) IrqIn = 6'($urandom);
            We   = ($urandom_range(0, 2) == 0);
            Addr = 2'($urandom_range(0, 3));
            WD   = $urandom;
            if (Addr == 2'd3) begin
                WD[31] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 1) == 1) WD[2:0] = 3'(mCur);
            end
            cycle();
            expRd = mdl_rd(Addr);
            checks++;
            if (IntReq !== (mPhase == 1)) begin
                errors++;
                if (prints < 20) $display("FAIL rand_intreq cyc %0d: got %0b want %0b", n, IntReq, mPhase == 1);
                prints++;
            end
            checks++;
            if (RD !== expRd) begin
                errors++;
                if (prints < 20) $display("FAIL rand_rd cyc %0d addr %0d: got %h want %h", n, Addr, RD, expRd);
                prints++;
            end
        end
        reset = 1'b0; We = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b0; We = 1'b0; Addr = '0; WD = '0; IrqIn = '0;
        test_reset();
        test_level_priority();
        test_edge_latch();
        test_handshake_guard();
        test_collision();
        test_masking();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
